// File: rtl/i2s_slave_rx.sv
// i2s_slave_rx: I2S slave receiver; oversamples external BCLK and publishes stereo words
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   i2s_bclk/lrclk/sdata external I2S pins (asynchronous to clk)
//   audio_ldata/rdata   last complete left/right words of one frame
//   audio_valid         1-clk strobe when audio_ldata/audio_rdata update
//   frame_err           1-clk strobe when a slot ends before DATA_WIDTH bits
module i2s_slave_rx #(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i2s_bclk,
    input  logic                  i2s_lrclk,
    input  logic                  i2s_sdata,
    output logic [DATA_WIDTH-1:0] audio_ldata,
    output logic [DATA_WIDTH-1:0] audio_rdata,
    output logic                  audio_valid,
    output logic                  frame_err
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {WAIT_EDGE, SHIFT, HOLD} state_t;
    state_t state, state_next;

    logic [SYNC_STAGES-1:0] bclk_sync, lr_sync, sd_sync;
    logic                   bclk_d, chan, prev_lr, left_ok;
    logic [CW-1:0]          bit_cnt;
    logic [DATA_WIDTH-2:0]  shreg;
    logic [DATA_WIDTH-1:0]  left_buf, word;
    logic                   bclk_s, lr, sdata, rise, slot_start, shift_en, commit, err;

    assign bclk_s     = bclk_sync[SYNC_STAGES-1];
    assign lr         = lr_sync[SYNC_STAGES-1];
    assign sdata      = sd_sync[SYNC_STAGES-1];
    assign rise       = bclk_s & ~bclk_d;
    // The rise that reveals an LRCLK change carries the previous slot's LSB/pad.
    assign slot_start = rise & (lr ^ prev_lr);
    assign word       = {shreg, sdata};
    assign commit     = shift_en & (bit_cnt == LAST);

    // Identical chains keep bclk, lrclk and sdata aligned to each other.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bclk_sync <= '0;
            lr_sync   <= '0;
            sd_sync   <= '0;
            bclk_d    <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], i2s_bclk};
            lr_sync   <= {lr_sync[SYNC_STAGES-2:0], i2s_lrclk};
            sd_sync   <= {sd_sync[SYNC_STAGES-2:0], i2s_sdata};
            bclk_d    <= bclk_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= WAIT_EDGE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        shift_en   = 1'b0;
        err        = 1'b0;
        case (state)
            WAIT_EDGE: if (slot_start) state_next = SHIFT;
            SHIFT: begin
                if (slot_start) err = 1'b1;
                else if (rise) begin
                    shift_en = 1'b1;
                    if (bit_cnt == LAST) state_next = HOLD;
                end
            end
            HOLD:      if (slot_start) state_next = SHIFT;
            default:   state_next = WAIT_EDGE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_lr     <= 1'b0;
            chan        <= 1'b0;
            bit_cnt     <= '0;
            shreg       <= '0;
            left_buf    <= '0;
            left_ok     <= 1'b0;
            audio_ldata <= '0;
            audio_rdata <= '0;
            audio_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            audio_valid <= commit & chan & left_ok;
            frame_err   <= err;
            if (rise) prev_lr <= lr;
            if (slot_start) begin
                chan    <= lr;
                bit_cnt <= '0;
                // A right word is only published after its own left word.
                if (err || !lr) left_ok <= 1'b0;
            end else if (shift_en) begin
                shreg   <= word[DATA_WIDTH-2:0];
                bit_cnt <= bit_cnt + 1'b1;
                if (commit && !chan) begin
                    left_buf <= word;
                    left_ok  <= 1'b1;
                end else if (commit && left_ok) begin
                    audio_ldata <= left_buf;
                    audio_rdata <= word;
                    left_ok     <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_i2s_slave_rx.sv
// tb_i2s_slave_rx: directed frame vectors and reset corner sequences for i2s_slave_rx
module tb_i2s_slave_rx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i2s_bclk = 1'b0;
    logic        i2s_lrclk = 1'b0;
    logic        i2s_sdata = 1'b0;
    logic [15:0] audio_ldata, audio_rdata;
    logic        audio_valid, frame_err;

    int total = 0;
    int bad = 0;
    int vcnt = 0;
    int ecnt = 0;
    logic pv = 1'b0;
    logic pe = 1'b0;
    logic [15:0] rl_q[$];
    logic [15:0] rr_q[$];

    typedef struct {
        int          llen;
        int          rlen;
        logic [15:0] l;
        logic [15:0] r;
        bit          pad;
        int          ev;
        int          ee;
        logic [15:0] xl;
        logic [15:0] xr;
    } vec_t;
    vec_t tbl[7];

    i2s_slave_rx dut (
        .clk(clk), .rst(rst),
        .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_sdata(i2s_sdata),
        .audio_ldata(audio_ldata), .audio_rdata(audio_rdata),
        .audio_valid(audio_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (audio_valid) begin
            vcnt++;
            rl_q.push_back(audio_ldata);
            rr_q.push_back(audio_rdata);
        end
        if (frame_err) ecnt++;
        if (audio_valid || frame_err) begin
            total++;
            if ((audio_valid && pv) || (frame_err && pe)) begin
                bad++;
                $display("FAIL pulse_width: valid=%b err=%b twice in a row", audio_valid, frame_err);
            end
        end
        pv <= audio_valid;
        pe <= frame_err;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_period(input bit c, input bit d);
        i2s_lrclk = c;
        i2s_sdata = d;
        i2s_bclk  = 1'b0;
        tick(4);
        i2s_bclk  = 1'b1;
        tick(4);
    endtask

    // One slot: a slot-start period carrying the previous LSB/pad, then len data bits MSB first.
    task automatic send_slot(input bit c, input logic [15:0] w, input int len, input bit pad);
        bit_period(c, pad);
        for (int i = 0; i < len; i++) bit_period(c, i < 16 ? w[15-i] : pad);
    endtask

    initial begin
        logic [15:0] el[100];
        logic [15:0] er[100];
        int n;
        tbl[0] = '{16, 16, 16'hA5C3, 16'h1234, 1'b0, 1, 0, 16'hA5C3, 16'h1234};
        tbl[1] = '{32, 32, 16'h8001, 16'h7FFE, 1'b1, 1, 0, 16'h8001, 16'h7FFE};
        tbl[2] = '{ 8, 16, 16'hABCD, 16'h5555, 1'b0, 0, 1, 16'h8001, 16'h7FFE};
        tbl[3] = '{16, 16, 16'h0F0F, 16'hF0F0, 1'b0, 1, 0, 16'h0F0F, 16'hF0F0};
        tbl[4] = '{24, 20, 16'hFFFF, 16'h0000, 1'b0, 1, 0, 16'hFFFF, 16'h0000};
        tbl[5] = '{16, 16, 16'h0000, 16'hFFFF, 1'b1, 1, 0, 16'h0000, 16'hFFFF};
        tbl[6] = '{17, 16, 16'h8000, 16'h0001, 1'b0, 1, 0, 16'h8000, 16'h0001};

        // reset held with random pin activity, then idle release
        for (int i = 0; i < 40; i++) begin
            i2s_bclk  = 1'($urandom);
            i2s_lrclk = 1'($urandom);
            i2s_sdata = 1'($urandom);
            tick(1);
            chk("t1_rst_outs", {audio_ldata, audio_rdata, audio_valid, frame_err}, 64'd0);
        end
        i2s_bclk = 1'b0;
        i2s_lrclk = 1'b0;
        i2s_sdata = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(20);
        chk("t1_rel_outs", {audio_ldata, audio_rdata}, 64'd0);
        chk("t1_rel_valid", vcnt, 0);
        chk("t1_rel_err", ecnt, 0);

        // release reset in the middle of a right slot
        rst = 1'b1;
        tick(2);
        bit_period(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) bit_period(1'b1, i[0]);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) bit_period(1'b1, i[1]);
        vcnt = 0;
        send_slot(1'b0, 16'h1111, 16, 1'b0);
        send_slot(1'b1, 16'h2222, 16, 1'b0);
        tick(8);
        chk("t5_valid_cnt", vcnt, 1);
        chk("t5_ldata", audio_ldata, 16'h1111);
        chk("t5_rdata", audio_rdata, 16'h2222);

        // frame table
        for (int k = 0; k < 7; k++) begin
            vcnt = 0;
            ecnt = 0;
            send_slot(1'b0, tbl[k].l, tbl[k].llen, tbl[k].pad);
            send_slot(1'b1, tbl[k].r, tbl[k].rlen, tbl[k].pad);
            tick(8);
            chk($sformatf("row%0d_valid", k), vcnt, tbl[k].ev);
            chk($sformatf("row%0d_err", k), ecnt, tbl[k].ee);
            chk($sformatf("row%0d_ldata", k), audio_ldata, tbl[k].xl);
            chk($sformatf("row%0d_rdata", k), audio_rdata, tbl[k].xr);
        end

        // async reset in a left slot, then 100 back-to-back frames
        bit_period(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) bit_period(1'b0, i[0]);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_outs", {audio_ldata, audio_rdata, audio_valid, frame_err}, 64'd0);
        tick(3);
        rst = 1'b0;
        for (int i = 0; i < 11; i++) bit_period(1'b0, i[0]);
        send_slot(1'b1, 16'hBEEF, 16, 1'b0);
        vcnt = 0;
        ecnt = 0;
        rl_q.delete();
        rr_q.delete();
        for (int k = 0; k < 100; k++) begin
            el[k] = 16'($urandom);
            er[k] = 16'($urandom);
            send_slot(1'b0, el[k], 16, 1'b0);
            send_slot(1'b1, er[k], 16, 1'b0);
        end
        tick(8);
        n = vcnt;
        total++;
        if (n != 99 && n != 100) begin
            bad++;
            $display("FAIL t6_valid_cnt: got %0d want 99 or 100", n);
        end
        chk("t6_err", ecnt, 0);
        if (n <= 100 && n == rl_q.size()) begin
            for (int k = 0; k < n; k++) begin
                chk($sformatf("t6_l%0d", k), rl_q[k], el[k + 100 - n]);
                chk($sformatf("t6_r%0d", k), rr_q[k], er[k + 100 - n]);
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
